// File: rtl/ir_timing_pkg.sv
// rtl/ir_timing_pkg.sv - shared IR timing constants, record type and FSM states
package ir_timing_pkg;

  localparam int IR_CLK_MHZ        = 8;
  localparam int IR_UNIT_COUNTS_US = 10;
  localparam int IR_MAX_DUR_W      = 32;

  typedef struct packed {
    logic                    level;
    logic                    timeout;
    logic [IR_MAX_DUR_W-1:0] duration;
  } ir_record_t;

  typedef enum logic {
    ST_IDLE,
    ST_MEASURE
  } pwm_state_t;

  function automatic int counts_per_unit(input int clk_mhz, input int unit_us);
    return clk_mhz * unit_us;
  endfunction

endpackage

// File: rtl/ir_input_conditioner.sv
// rtl/ir_input_conditioner.sv - IR line synchroniser with optional glitch filter
// Optional filter: PULSE_WIDTH_METER_GLITCH_FILTER_EN
module ir_input_conditioner #(
  parameter logic IDLE_LEVEL    = 1'b1,
  parameter int   GLITCH_CYCLES = 4
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic ir_in,
  output logic level_out
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], ir_in};
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) sync_q <= {2{IDLE_LEVEL}};
    else          sync_q <= sync_d;
  end

`ifdef PULSE_WIDTH_METER_GLITCH_FILTER_EN
  localparam int CW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;

  logic [CW-1:0] run_q, run_d;
  logic          filt_q, filt_d;

  // run counts consecutive samples that disagree with the accepted level
  always_comb begin
    run_d  = '0;
    filt_d = filt_q;
    if (sync_q[1] != filt_q) begin
      if (run_q == CW'(GLITCH_CYCLES - 1)) filt_d = sync_q[1];
      else                                 run_d  = run_q + 1'b1;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      run_q  <= '0;
      filt_q <= IDLE_LEVEL;
    end else begin
      run_q  <= run_d;
      filt_q <= filt_d;
    end
  end

  assign level_out = filt_q;
`else
  logic [31:0] glitch_cycles_unused;
  assign glitch_cycles_unused = 32'(GLITCH_CYCLES);
  assign level_out = sync_q[1];
`endif

endmodule

// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - IR mark/space width meter with single-entry record register
// Optional input glitch filter: PULSE_WIDTH_METER_GLITCH_FILTER_EN
module pulse_width_meter
  import ir_timing_pkg::*;
#(
  parameter int   WIDTH          = 16,
  parameter int   UNIT_COUNTS_US = IR_UNIT_COUNTS_US,
  parameter int   CLK_MHZ        = IR_CLK_MHZ,
  parameter logic IDLE_LEVEL     = 1'b1,
  parameter int   TIMEOUT_UNITS  = 2000,
  parameter int   GLITCH_CYCLES  = 4
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             enable_in,
  input  logic             ir_in,
  output logic             record_valid_out,
  input  logic             record_ready_in,
  output logic             record_level_out,
  output logic [WIDTH-1:0] record_duration_out,
  output logic             record_timeout_out,
  output logic             overflow_out,
  input  logic             overflow_clear_in,
  output logic             busy_out
);

  localparam int COUNTS_PER_UNIT = counts_per_unit(CLK_MHZ, UNIT_COUNTS_US);
  localparam int PW = (COUNTS_PER_UNIT > 1) ? $clog2(COUNTS_PER_UNIT) : 1;
  localparam logic [PW-1:0]    PRE_RELOAD = PW'(COUNTS_PER_UNIT - 1);
  localparam logic [WIDTH-1:0] DUR_MAX    = {WIDTH{1'b1}};
  // A timeout beyond the counter range fires at saturation instead
  localparam logic [WIDTH-1:0] TIMEOUT_EFF =
    (longint'(TIMEOUT_UNITS) > ((longint'(1) << WIDTH) - 1)) ? DUR_MAX : WIDTH'(TIMEOUT_UNITS);

  pwm_state_t       state_q, state_d;
  logic             level_sync, level_q, level_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] dur_q, dur_d, dur_inc;
  logic             tick, edge_det, new_rec;
  ir_record_t       rec_new, rec_q, rec_d;
  logic             valid_q, valid_d, ovf_q, ovf_d;
  logic [IR_MAX_DUR_W-1:0] rec_duration_unused;

  ir_input_conditioner #(
    .IDLE_LEVEL   (IDLE_LEVEL),
    .GLITCH_CYCLES(GLITCH_CYCLES)
  ) u_cond (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .ir_in    (ir_in),
    .level_out(level_sync)
  );

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state, interval counters and record generation
  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    dur_d    = dur_q;
    level_d  = level_sync;
    new_rec  = 1'b0;
    rec_new  = '0;
    edge_det = (level_sync != level_q);
    tick     = (pre_q == '0);
    dur_inc  = (tick && dur_q != DUR_MAX) ? dur_q + 1'b1 : dur_q;
    if (!enable_in) begin
      state_d = ST_IDLE;
      pre_d   = PRE_RELOAD;
      dur_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pre_d = PRE_RELOAD;
          dur_d = '0;
          if (edge_det && level_sync != IDLE_LEVEL) state_d = ST_MEASURE;
        end
        ST_MEASURE: begin
          pre_d = tick ? PRE_RELOAD : pre_q - 1'b1;
          dur_d = dur_inc;
          if (edge_det) begin
            new_rec                        = 1'b1;
            rec_new.level                  = (level_q != IDLE_LEVEL);
            rec_new.duration[WIDTH-1:0]    = dur_inc;
            pre_d                          = PRE_RELOAD;
            dur_d                          = '0;
          end else if (level_q == IDLE_LEVEL && dur_inc >= TIMEOUT_EFF) begin
            new_rec                        = 1'b1;
            rec_new.timeout                = 1'b1;
            rec_new.duration[WIDTH-1:0]    = TIMEOUT_EFF;
            state_d                        = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Single-entry holding register; a refused record is dropped and flagged
  always_comb begin
    rec_d   = rec_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (new_rec && (!valid_q || record_ready_in)) begin
      rec_d   = rec_new;
      valid_d = 1'b1;
    end else if (valid_q && record_ready_in) begin
      valid_d = 1'b0;
    end
    if (overflow_clear_in)                        ovf_d = 1'b0;
    if (new_rec && valid_q && !record_ready_in)   ovf_d = 1'b1;
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      level_q <= IDLE_LEVEL;
      pre_q   <= PRE_RELOAD;
      dur_q   <= '0;
      rec_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      pre_q   <= pre_d;
      dur_q   <= dur_d;
      rec_q   <= rec_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    busy_out = (state_q == ST_MEASURE);
  end

  assign rec_duration_unused = rec_q.duration;
  assign record_valid_out    = valid_q;
  assign record_level_out    = rec_q.level;
  assign record_timeout_out  = rec_q.timeout;
  assign record_duration_out = rec_q.duration[WIDTH-1:0];
  assign overflow_out        = ovf_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb/tb_pulse_width_meter.sv - scoreboard bench for pulse_width_meter
module tb_pulse_width_meter;

  typedef struct {
    logic lvl;
    logic to;
    int   dur;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic clr = 1'b0;
  logic ir_a = 1'b1, ready_a = 1'b1;
  logic ir_b = 1'b1, ready_b = 1'b1;

  logic        valid_a, level_a, to_a, ovf_a, busy_a;
  logic [15:0] dur_a;
  logic        valid_b, level_b, to_b, ovf_b, busy_b;
  logic [7:0]  dur_b;

  int checks = 0;
  int errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  always #5 clk = ~clk;

  pulse_width_meter #(.WIDTH(16), .TIMEOUT_UNITS(100)) dut_a (
    .clock_in(clk), .reset_in(rst), .enable_in(en), .ir_in(ir_a),
    .record_valid_out(valid_a), .record_ready_in(ready_a),
    .record_level_out(level_a), .record_duration_out(dur_a),
    .record_timeout_out(to_a), .overflow_out(ovf_a),
    .overflow_clear_in(clr), .busy_out(busy_a)
  );

  pulse_width_meter #(.WIDTH(8), .TIMEOUT_UNITS(100)) dut_b (
    .clock_in(clk), .reset_in(rst), .enable_in(en), .ir_in(ir_b),
    .record_valid_out(valid_b), .record_ready_in(ready_b),
    .record_level_out(level_b), .record_duration_out(dur_b),
    .record_timeout_out(to_b), .overflow_out(ovf_b),
    .overflow_clear_in(clr), .busy_out(busy_b)
  );

  always @(negedge clk) begin
    if (!rst && valid_a && ready_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL rec_a unexpected: got lvl=%0b dur=%0d to=%0b, want none", level_a, dur_a, to_a);
      end else begin
        ea = q_a.pop_front();
        if (level_a !== ea.lvl || dur_a !== 16'(ea.dur) || to_a !== ea.to) begin
          errors++;
          $display("FAIL rec_a: got lvl=%0b dur=%0d to=%0b, want lvl=%0b dur=%0d to=%0b",
                   level_a, dur_a, to_a, ea.lvl, ea.dur, ea.to);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid_b && ready_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL rec_b unexpected: got lvl=%0b dur=%0d to=%0b, want none", level_b, dur_b, to_b);
      end else begin
        eb = q_b.pop_front();
        if (level_b !== eb.lvl || dur_b !== 8'(eb.dur) || to_b !== eb.to) begin
          errors++;
          $display("FAIL rec_b: got lvl=%0b dur=%0d to=%0b, want lvl=%0b dur=%0d to=%0b",
                   level_b, dur_b, to_b, eb.lvl, eb.dur, eb.to);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic lvl, input logic to, input int dur);
    q_a.push_back('{lvl: lvl, to: to, dur: dur});
  endtask

  task automatic push_b(input logic lvl, input logic to, input int dur);
    q_b.push_back('{lvl: lvl, to: to, dur: dur});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid_a); end
    checks++; if (level_a !== 1'b0) begin errors++; $display("FAIL reset_level: got %0b want 0", level_a); end
    checks++; if (dur_a !== 16'd0) begin errors++; $display("FAIL reset_dur: got %0d want 0", dur_a); end
    checks++; if (to_a !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b want 0", to_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", ovf_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy_a); end
    checks++; if (valid_b !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_b: got valid=%0b busy=%0b want 0 0", valid_b, busy_b); end
    rst = 1'b0;
    cyc(5);
  endtask

  task automatic test_frame();
    ir_a = 1'b0; push_a(1'b1, 1'b0, 90);  cyc(7200);
    ir_a = 1'b1; push_a(1'b0, 1'b0, 45);  cyc(3600);
    ir_a = 1'b0; push_a(1'b1, 1'b0, 5);   cyc(448);
    ir_a = 1'b1; push_a(1'b0, 1'b1, 100); cyc(7990);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL frame_busy_before_timeout: got %0b want 1", busy_a); end
    cyc(20);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL frame_busy_after_timeout: got %0b want 0", busy_a); end
    checks++; if (q_a.size() != 0) begin errors++; $display("FAIL frame_pending: got %0d records outstanding want 0", q_a.size()); end
  endtask

  task automatic test_unit_boundaries();
    ir_a = 1'b0; push_a(1'b1, 1'b0, 0);   cyc(79);
    ir_a = 1'b1; push_a(1'b0, 1'b0, 1);   cyc(81);
    ir_a = 1'b0; push_a(1'b1, 1'b0, 1);   cyc(80);
    ir_a = 1'b1; push_a(1'b0, 1'b0, 2);   cyc(160);
    ir_a = 1'b0; push_a(1'b1, 1'b0, 0);   cyc(10);
    ir_a = 1'b1; push_a(1'b0, 1'b1, 100); cyc(8010);
    checks++; if (q_a.size() != 0) begin errors++; $display("FAIL boundary_pending: got %0d records outstanding want 0", q_a.size()); end
  endtask

  task automatic test_saturation();
    ir_b = 1'b0; push_b(1'b1, 1'b0, 255); cyc(24000);
    ir_b = 1'b1; push_b(1'b0, 1'b1, 100); cyc(8010);
    checks++; if (q_b.size() != 0) begin errors++; $display("FAIL sat_pending: got %0d records outstanding want 0", q_b.size()); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL sat_busy: got %0b want 0", busy_b); end
  endtask

  task automatic test_back_to_back();
    ready_a = 1'b0;
    ir_a = 1'b0; cyc(200);
    ir_a = 1'b1; push_a(1'b1, 1'b0, 2); cyc(300);
    ir_a = 1'b0; cyc(400);
    checks++; if (valid_a !== 1'b1 || level_a !== 1'b1 || dur_a !== 16'd2 || to_a !== 1'b0)
      begin errors++; $display("FAIL hold_stable: got v=%0b l=%0b d=%0d t=%0b want 1 1 2 0", valid_a, level_a, dur_a, to_a); end
    checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL overflow_set: got %0b want 1", ovf_a); end
    ir_a = 1'b1; push_a(1'b1, 1'b0, 5); cyc(2);
    ready_a = 1'b1; cyc(1);
    checks++; if (valid_a !== 1'b1 || level_a !== 1'b1 || dur_a !== 16'd5)
      begin errors++; $display("FAIL no_bubble_load: got v=%0b l=%0b d=%0d want 1 1 5", valid_a, level_a, dur_a); end
    cyc(2);
    checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %0b want 1", ovf_a); end
    clr = 1'b1; cyc(1); clr = 1'b0;
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %0b want 0", ovf_a); end
    en = 1'b0; cyc(3);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL disable_idle: got %0b want 0", busy_a); end
    en = 1'b1; cyc(20);
    checks++; if (q_a.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d records outstanding want 0", q_a.size()); end
  endtask

  task automatic test_async_reset_enable();
    ir_a = 1'b0; cyc(500);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL mark_busy: got %0b want 1", busy_a); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy_a !== 1'b0 || valid_a !== 1'b0 || dur_a !== 16'd0)
      begin errors++; $display("FAIL async_reset: got busy=%0b valid=%0b dur=%0d want 0 0 0", busy_a, valid_a, dur_a); end
    ir_a = 1'b1; cyc(3);
    rst = 1'b0; cyc(5);
    ir_a = 1'b0; push_a(1'b1, 1'b0, 12); cyc(1000);
    ir_a = 1'b1; push_a(1'b0, 1'b0, 2);  cyc(200);
    ir_a = 1'b0; cyc(500);
    en = 1'b0; cyc(2);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL enable_low_busy: got %0b want 0", busy_a); end
    ir_a = 1'b1; cyc(5);
    en = 1'b1; cyc(20);
    checks++; if (q_a.size() != 0 || valid_a !== 1'b0)
      begin errors++; $display("FAIL enable_low_record: got %0d outstanding valid=%0b want 0 0", q_a.size(), valid_a); end
  endtask

`ifdef PULSE_WIDTH_METER_GLITCH_FILTER_EN
  task automatic test_glitch_filter();
    ir_a = 1'b0; push_a(1'b1, 1'b0, 37); cyc(2000);
    ir_a = 1'b1; cyc(3);
    ir_a = 1'b0; cyc(1000);
    checks++; if (busy_a !== 1'b1 || q_a.size() != 1)
      begin errors++; $display("FAIL glitch_ignored: got busy=%0b outstanding=%0d want 1 1", busy_a, q_a.size()); end
    ir_a = 1'b1; push_a(1'b0, 1'b0, 0);   cyc(5);
    ir_a = 1'b0; push_a(1'b1, 1'b0, 25);  cyc(2000);
    ir_a = 1'b1; push_a(1'b0, 1'b1, 100); cyc(8010);
    checks++; if (q_a.size() != 0) begin errors++; $display("FAIL glitch_pending: got %0d outstanding want 0", q_a.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_unit_boundaries();
    test_saturation();
    test_back_to_back();
    test_async_reset_enable();
`ifdef PULSE_WIDTH_METER_GLITCH_FILTER_EN
    test_glitch_filter();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
